// File: rtl/seq_mult16_if.sv
// Request/result bundle between the controlling logic and seq_mult16.
interface seq_mult16_if;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] product;
    logic        busy;
    logic        done;

    // Controller side: issues requests, observes status and result.
    modport master (
        output start, a, b,
        input  product, busy, done
    );

    // Multiplier side.
    modport slave (
        input  start, a, b,
        output product, busy, done
    );
endinterface

// File: rtl/seq_mult16.sv
// seq_mult16: 16x16 unsigned shift-and-add multiplier, one partial product
// per cycle through a 16-bit carry-lookahead adder (four 4-bit lookahead
// blocks, carry rippled between blocks). 16 RUN cycles, one DONE cycle.
module seq_mult16 (
    input  logic          clk,
    input  logic          rst,
    seq_mult16_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] m;
    logic [31:0] p;
    logic [3:0]  cnt;
    logic [31:0] p_nxt;
    logic [15:0] sum;
    logic        cout;

    // Group propagate/generate are not needed by the multiplier.
    logic [3:0]  unused_grp_p;
    logic [3:0]  unused_grp_g;

    cla16 u_add (
        .a     (p[31:16]),
        .b     (m),
        .cin   (1'b0),
        .sum   (sum),
        .cout  (cout),
        .grp_p (unused_grp_p),
        .grp_g (unused_grp_g)
    );

    // Shift-add step: carry-out lands in P[31], so nothing is lost.
    always_comb begin
        p_nxt = {1'b0, p[31:16], p[15:1]};
        if (p[0])
            p_nxt = {cout, sum, p[15:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (cnt == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate in RUN, publish on last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m           <= '0;
            p           <= '0;
            cnt         <= '0;
            bus.product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m   <= bus.a;
                        p   <= {16'h0000, bus.b};
                        cnt <= '0;
                    end
                end
                RUN: begin
                    p   <= p_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        bus.product <= p_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// 16-bit adder: four lookahead blocks, carry rippled block to block.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout,
    output logic [3:0]  grp_p,
    output logic [3:0]  grp_g
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_blk
        cla4 u_blk (
            .a     (a[4*i +: 4]),
            .b     (b[4*i +: 4]),
            .cin   (c[i]),
            .sum   (sum[4*i +: 4]),
            .cout  (c[i+1]),
            .grp_p (grp_p[i]),
            .grp_g (grp_g[i])
        );
    end

    assign cout = c[4];
endmodule

// 4-bit carry-lookahead block.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       grp_p,
    output logic       grp_g
);
    logic [3:0] g, pr;
    logic [3:0] c;

    assign g  = a & b;
    assign pr = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (pr[0] & cin);
    assign c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & cin);
    assign c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0])
                | (pr[2] & pr[1] & pr[0] & cin);

    assign grp_p = &pr;
    assign grp_g = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1])
                 | (pr[3] & pr[2] & pr[1] & g[0]);
    assign cout  = grp_g | (grp_p & cin);
    assign sum   = pr ^ c;
endmodule
